// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a busy/done status word.
module uart_tx_mmio #(
    parameter int WORD_LENGTH = 32,
    parameter int BAUD_DIV    = 434,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enableUART,
    input  logic                   MemWrite,
    input  logic [WORD_LENGTH-1:0] WriteData,
    output logic [WORD_LENGTH-1:0] ReadData,
    output logic                   tx,
    output logic                   busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(BAUD_DIV - 1);

    logic [1:0]           state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 last, accept;
    logic                 unused_bits;

    assign unused_bits = ^WriteData[WORD_LENGTH-1:8];
    assign last        = cnt_q == LAST;
    assign accept      = enableUART && MemWrite && !busy_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = done_q;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    shift_d = WriteData[7:0];
                    done_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (last) begin
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    state_d = idx_q == 3'd7 ? STOP : DATA;
                end
            end
            default: begin
                if (last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // tx decodes registered state, so an asynchronous reset forces it high at once
    assign tx       = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    assign busy     = busy_q;
    assign ReadData = {{(WORD_LENGTH-2){1'b0}}, done_q, busy_q};
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter placed directly downstream of the address comparator. It consumes the comparator's UART enable, qualified by the processor's memory-write strobe, and captures WriteData[7:0] at data address 0x10010020. It serialises the byte as 8N1, LSB first, on a single tx line. A status word is returned to the read-data mux so software can poll for busy and done.

Parameters:
WORD_LENGTH, 32, width of the processor data bus and of ReadData
BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); legal range 2..65535
CNT_WIDTH, 16, width of the baud counter; must hold BAUD_DIV-1

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
enableUART  input  1  address-match strobe from the comparator (address 0x10010020)
MemWrite  input  1  processor store strobe
WriteData  input  WORD_LENGTH  store data; only bits [7:0] are used
ReadData  output  WORD_LENGTH  status word: bit0 = busy, bit1 = done; bits [WORD_LENGTH-1:2] = 0
tx  output  1  serial line; idles high
busy  output  1  frame in progress; same value as ReadData[0]

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, tx=1, busy=0, done=0, shift register=0, baud counter=0, bit index=0.
  - Takes effect immediately, including mid-frame. tx returns high in the same cycle, and the aborted frame is not resumed.
- Accept condition: enableUART && MemWrite && !busy at a rising edge.
  - The byte is latched into the shift register, done clears, and state goes to START.
  - busy=1 from the following cycle.
- Write while busy is ignored. No data is captured and the done/busy flags are unchanged.
- enableUART=1 with MemWrite=0 has no effect. This is a status read.
- FSM states and transitions:
  - IDLE: tx=1. Moves to START on accept.
  - START: tx=0 for BAUD_DIV cycles, then DATA with bit index=0.
  - DATA: tx=shift[0] for BAUD_DIV cycles per bit. At the end of each bit, shift right by 1 and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles, then IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and resets to 0 at each bit boundary and on every state change.
  - The bit period ends when the counter equals BAUD_DIV-1.
- Frame length: exactly 10*BAUD_DIV cycles from the first tx=0 cycle to the return to IDLE.
  - The first tx=0 cycle is the cycle after the accepting edge.
- busy is 1 in START, DATA and STOP, and 0 in IDLE. It is a registered output with no combinational path from inputs.
- done:
  - Set to 1 on the edge that moves STOP to IDLE.
  - Held until the next accepted write or reset.
- Back-to-back writes:
  - A write in the final STOP cycle is still rejected, because busy=1.
  - A write in the first IDLE cycle is accepted, giving a minimum of one idle-high cycle between frames.
- ReadData is combinational from the registered busy/done flags and is valid every cycle regardless of enableUART. Mux selection is the read-path's responsibility.
- WriteData[WORD_LENGTH-1:8] is ignored.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles, then release → tx=1, busy=0, ReadData=0x00000000. Stays so for 20 cycles with no strobes.
- Single frame (BAUD_DIV=4): write 0x000000A5 with enableUART=1, MemWrite=1 for 1 cycle.
  - Expect tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, for 40 cycles total.
  - busy=1 throughout; then ReadData=0x00000002.
- Ignored write: during the frame above, write 0x000000FF at cycle 10 → serial output is still 0xA5 and no second frame follows.
- Non-write strobe: enableUART=1, MemWrite=0, WriteData=0x55 → no frame starts, tx stays 1.
- Back-to-back: write 0x3C, then write 0xC3 in the first cycle busy drops.
  - The first frame is 0x3C and the second is 0xC3.
  - Exactly 1 idle-high cycle between the two stop and start bits.
  - done=0 during the second frame.
- Reset mid-frame: assert reset=0 during data bit 3 of 0x0F → tx=1 and busy=0 immediately (asynchronous). After release, ReadData=0 and a new write of 0x81 transmits correctly.
